irq_sync_collect: RTL

IRQ_SYNC_COLLECT -- requirements
Module: irq_sync_collect

---
 rtl/irq_sync_collect.sv | 138 +++++++++++++
 1 files changed

// File: rtl/irq_sync_collect.sv
// Interrupt request collector: synchronizes an asynchronous request level, detects
// rising edges and counts them into a pending-interrupt register until acknowledged.
module irq_sync_collect #(
  parameter int SYNC = 2,
  parameter int CNTW = 4
) (
  input  logic            CLK,
  input  logic            R,
  input  logic            A,
  input  logic            EN,
  input  logic            ACK,
  output logic            IRQ,
  output logic [CNTW-1:0] CNT,
  output logic            OVF
);

  localparam logic [1:0] ST_ARM  = 2'd0;
  localparam logic [1:0] ST_IDLE = 2'd1;
  localparam logic [1:0] ST_PEND = 2'd2;

  localparam logic [CNTW-1:0] CNT_MAX = '1;
  localparam logic [CNTW-1:0] CNT_ONE = CNTW'(1);

  localparam int              ARMW     = $clog2(SYNC + 1);
  localparam logic [ARMW-1:0] ARM_DONE = ARMW'(SYNC);

  if (SYNC < 2 || SYNC > 4) begin : g_bad_sync
    $error("irq_sync_collect: SYNC must be in 2..4");
  end
  if (CNTW < 2 || CNTW > 8) begin : g_bad_cntw
    $error("irq_sync_collect: CNTW must be in 2..8");
  end

  logic [SYNC-1:0] sync_q;
  logic            ad_q;
  logic            as_w;
  logic            edge_w;
  logic            qual_w;

  logic [1:0]      state_q, state_d;
  logic [ARMW-1:0] arm_cnt_q, arm_cnt_d;
  logic [CNTW-1:0] cnt_q, cnt_d;
  logic            ovf_q, ovf_d;
  logic            irq_q, irq_d;

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge value of its neighbours, which is what makes the chain a chain.
  always_ff @(posedge CLK or negedge R) begin
    if (!R) begin
      sync_q <= '0;
      ad_q   <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC-2:0], A};
      ad_q   <= as_w;
    end
  end

  assign as_w   = sync_q[SYNC-1];
  assign edge_w = as_w & ~ad_q;
  assign qual_w = edge_w & EN;

  // The chain resets to 0, so right after reset As does not yet reflect A. ARM
  // waits until SYNC post-reset samples have reached As before trusting As=0;
  // this keeps a request held high across reset from looking like a fresh edge.
  // NOTE: every variable gets a default at the top of always_comb so that no
  // path through the case leaves one unassigned and infers a latch.
  always_comb begin
    state_d   = state_q;
    arm_cnt_d = arm_cnt_q;
    cnt_d     = cnt_q;
    ovf_d     = ovf_q;

    case (state_q)
      ST_ARM: begin
        if (arm_cnt_q != ARM_DONE) begin
          arm_cnt_d = arm_cnt_q + 1'b1;
        end else if (!as_w) begin
          state_d = ST_IDLE;
        end
      end

      ST_IDLE: begin
        if (qual_w) begin
          state_d = ST_PEND;
          cnt_d   = CNT_ONE;
        end
      end

      ST_PEND: begin
        if (ACK) begin
          ovf_d = 1'b0;
          if (qual_w) begin
            cnt_d = CNT_ONE;
          end else begin
            state_d = ST_IDLE;
            cnt_d   = '0;
          end
        end else if (qual_w) begin
          if (cnt_q == CNT_MAX) begin
            ovf_d = 1'b1;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end

      default: begin
        state_d   = ST_ARM;
        arm_cnt_d = '0;
        cnt_d     = '0;
        ovf_d     = 1'b0;
      end
    endcase

    irq_d = (state_d == ST_PEND);
  end

  always_ff @(posedge CLK or negedge R) begin
    if (!R) begin
      state_q   <= ST_ARM;
      arm_cnt_q <= '0;
      cnt_q     <= '0;
      ovf_q     <= 1'b0;
      irq_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      arm_cnt_q <= arm_cnt_d;
      cnt_q     <= cnt_d;
      ovf_q     <= ovf_d;
      irq_q     <= irq_d;
    end
  end

  assign IRQ = irq_q;
  assign CNT = cnt_q;
  assign OVF = ovf_q;

endmodule
